// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register.
// A command loads one word into the register. It then shifts or rotates that
// word by a programmable number of positions, driving {s1,s0}, pa_in and the
// serial inputs on every cycle. Rotate takes its serial bit from the
// register's own end outputs.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             cmd_dir,
    input  logic             cmd_rot,
    input  logic             cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             left_out_fb,
    input  logic             right_out_fb,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] pa_in,
    output logic             left_in,
    output logic             right_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Register mode select encoding {s1,s0}.
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    state_t             state;
    state_t             state_nxt;
    logic               dir_q;
    logic               rot_q;
    logic               fill_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   remaining;
    logic [1:0]         mode;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the command in IDLE and count shifts down while in SHIFT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dir_q     <= 1'b0;
            rot_q     <= 1'b0;
            fill_q    <= 1'b0;
            data_q    <= '0;
            remaining <= '0;
        end else if (state == ST_IDLE && start) begin
            dir_q     <= cmd_dir;
            rot_q     <= cmd_rot;
            fill_q    <= cmd_fill;
            data_q    <= cmd_data;
            remaining <= cmd_count;
        end else if (state == ST_SHIFT) begin
            // The FSM leaves SHIFT when remaining is 1, so this never wraps.
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Next-state decode.
    // NOTE: assigning a default before the case keeps every path assigned,
    // so no latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (remaining == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (remaining == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs from state and the latched command. The rotate serial
    // bit passes straight through from the register's opposite end.
    always_comb begin
        mode     = MODE_HOLD;
        pa_in    = '0;
        left_in  = 1'b0;
        right_in = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                mode  = MODE_LOAD;
                pa_in = data_q;
                busy  = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (dir_q) begin
                    mode     = MODE_LEFT;
                    right_in = rot_q ? left_out_fb : fill_q;
                end else begin
                    mode    = MODE_RIGHT;
                    left_in = rot_q ? right_out_fb : fill_q;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign s1 = mode[1];
    assign s0 = mode[0];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl. A behavioural 4-bit universal shift
// register is connected in the loop, so that rotate feedback and the final
// register contents can be checked against hand-computed words.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             clr;
    logic             start;
    logic             cmd_dir;
    logic             cmd_rot;
    logic             cmd_fill;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] pa_in;
    logic             left_in;
    logic             right_in;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] sr_q = '0;

    int n_checks = 0;
    int n_pass   = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .cmd_dir      (cmd_dir),
        .cmd_rot      (cmd_rot),
        .cmd_fill     (cmd_fill),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .left_out_fb  (sr_q[WIDTH-1]),
        .right_out_fb (sr_q[0]),
        .s0           (s0),
        .s1           (s1),
        .pa_in        (pa_in),
        .left_in      (left_in),
        .right_in     (right_in),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register model: no reset, so it keeps its value across clr.
    always @(posedge clk) begin
        case ({s1, s0})
            2'b01:   sr_q <= {sr_q[WIDTH-2:0], right_in};
            2'b10:   sr_q <= {left_in, sr_q[WIDTH-1:1]};
            2'b11:   sr_q <= pa_in;
            default: sr_q <= sr_q;
        endcase
    end

    // Present a command and hold start until the DUT enters LOAD.
    // Returns at edge E0 + 1, together with the number of edges needed.
    task automatic issue(input logic dir, input logic rot, input logic fill,
                         input logic [CNT_W-1:0] count, input logic [WIDTH-1:0] data,
                         output int edges);
        cmd_dir   = dir;
        cmd_rot   = rot;
        cmd_fill  = fill;
        cmd_count = count;
        cmd_data  = data;
        start     = 1'b1;
        edges     = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            edges++;
            if (busy) break;
        end
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL issue_timeout: busy=%b required 1", busy);
        else
            n_pass++;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int edges;
        clr = 1'b0;
        #3;
        n_checks++;
        if ({s1, s0, pa_in, left_in, right_in, busy, done} !== '0)
            $display("FAIL reset_outputs: s=%b%b pa=%b li=%b ri=%b busy=%b done=%b required all 0",
                     s1, s0, pa_in, left_in, right_in, busy, done);
        else n_pass++;
        step(); clr = 1'b1; step();

        // Reset in the middle of a right fill of zeros: 1001 -> 0100 -> 0010.
        issue(1'b0, 1'b0, 1'b0, 3'd5, 4'b1001, edges);
        step(); step(); step();
        n_checks++;
        if (sr_q !== 4'b0010 || busy !== 1'b1)
            $display("FAIL reset_pre: reg=%b busy=%b required 0010/1", sr_q, busy);
        else n_pass++;
        #2 clr = 1'b0;
        #1;
        n_checks++;
        if ({s1, s0, busy, done, left_in} !== 5'b0)
            $display("FAIL reset_async: s=%b%b busy=%b done=%b li=%b required 0",
                     s1, s0, busy, done, left_in);
        else n_pass++;
        step(); step();
        clr = 1'b1;
        step(); step();
        n_checks++;
        if (sr_q !== 4'b0010 || {s1, s0} !== 2'b00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_release: reg=%b s=%b%b busy=%b done=%b required 0010/00/0/0",
                     sr_q, s1, s0, busy, done);
        else n_pass++;
    endtask

    task automatic test_load_only;
        int edges;
        issue(1'b0, 1'b0, 1'b0, 3'd0, 4'b1001, edges);
        n_checks++;
        if ({s1, s0} !== 2'b11 || pa_in !== 4'b1001 || busy !== 1'b1)
            $display("FAIL load_only_load: s=%b%b pa=%b busy=%b required 11/1001/1", s1, s0, pa_in, busy);
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {s1, s0} !== 2'b00 || sr_q !== 4'b1001)
            $display("FAIL load_only_done: done=%b busy=%b s=%b%b reg=%b required 1/0/00/1001",
                     done, busy, s1, s0, sr_q);
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sr_q !== 4'b1001)
            $display("FAIL load_only_idle: done=%b busy=%b reg=%b required 0/0/1001", done, busy, sr_q);
        else n_pass++;
    endtask

    task automatic test_right_fill;
        int edges;
        issue(1'b0, 1'b0, 1'b1, 3'd1, 4'b1001, edges);
        step();
        n_checks++;
        if ({s1, s0} !== 2'b10 || left_in !== 1'b1 || right_in !== 1'b0 || pa_in !== '0 ||
            busy !== 1'b1 || sr_q !== 4'b1001)
            $display("FAIL right_fill_shift: s=%b%b li=%b ri=%b pa=%b busy=%b reg=%b required 10/1/0/0000/1/1001",
                     s1, s0, left_in, right_in, pa_in, busy, sr_q);
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b1 || sr_q !== 4'b1100 || busy !== 1'b0)
            $display("FAIL right_fill_done: done=%b reg=%b busy=%b required 1/1100/0", done, sr_q, busy);
        else n_pass++;
        step();
    endtask

    task automatic test_right_rotate;
        int edges;
        issue(1'b0, 1'b1, 1'b0, 3'd2, 4'b1001, edges);
        step();
        n_checks++;
        if (sr_q !== 4'b1001 || left_in !== 1'b1 || right_in !== 1'b0)
            $display("FAIL right_rot_1: reg=%b li=%b ri=%b required 1001/1/0", sr_q, left_in, right_in);
        else n_pass++;
        step();
        n_checks++;
        if (sr_q !== 4'b1100 || left_in !== 1'b0 || {s1, s0} !== 2'b10)
            $display("FAIL right_rot_2: reg=%b li=%b s=%b%b required 1100/0/10", sr_q, left_in, s1, s0);
        else n_pass++;
        step();
        n_checks++;
        if (sr_q !== 4'b0110 || done !== 1'b1)
            $display("FAIL right_rot_done: reg=%b done=%b required 0110/1", sr_q, done);
        else n_pass++;
    endtask

    // Left fill of ones, then a left rotate by WIDTH issued as soon as possible.
    task automatic test_back_to_back;
        int edges;
        logic [WIDTH-1:0] exp_seq [4];
        exp_seq[0] = 4'b0110;
        exp_seq[1] = 4'b1101;
        exp_seq[2] = 4'b1011;
        exp_seq[3] = 4'b0111;
        step();
        issue(1'b1, 1'b0, 1'b1, 3'd3, 4'b0110, edges);
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (sr_q !== exp_seq[k] || {s1, s0} !== 2'b01 || right_in !== 1'b1 || left_in !== 1'b0)
                $display("FAIL left_fill_%0d: reg=%b s=%b%b ri=%b li=%b required %b/01/1/0",
                         k, sr_q, s1, s0, right_in, left_in, exp_seq[k]);
            else n_pass++;
        end
        step();
        n_checks++;
        if (sr_q !== exp_seq[3] || done !== 1'b1)
            $display("FAIL left_fill_done: reg=%b done=%b required 0111/1", sr_q, done);
        else n_pass++;

        // Start is ignored in DONE, so LOAD follows two edges later.
        issue(1'b1, 1'b1, 1'b0, 3'd4, 4'b0110, edges);
        n_checks++;
        if (edges !== 2)
            $display("FAIL b2b_spacing: edges=%0d required 2", edges);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (sr_q !== 4'b1100 || right_in !== 1'b1)
            $display("FAIL left_rot_fb: reg=%b ri=%b required 1100/1", sr_q, right_in);
        else n_pass++;
        step(); step(); step();
        n_checks++;
        if (sr_q !== 4'b0110 || done !== 1'b1)
            $display("FAIL left_rot_done: reg=%b done=%b required 0110/1", sr_q, done);
        else n_pass++;
        step();
    endtask

    task automatic test_start_busy;
        int edges;
        // Left fill of zeros: 1010 -> 0100 -> 1000.
        issue(1'b1, 1'b0, 1'b0, 3'd2, 4'b1010, edges);
        cmd_dir   = 1'b0;
        cmd_rot   = 1'b1;
        cmd_count = 3'd7;
        cmd_data  = 4'b1111;
        start     = 1'b1;
        step();
        n_checks++;
        if ({s1, s0} !== 2'b01 || sr_q !== 4'b1010)
            $display("FAIL busy_start_shift: s=%b%b reg=%b required 01/1010", s1, s0, sr_q);
        else n_pass++;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b1 || sr_q !== 4'b1000)
            $display("FAIL busy_start_done: done=%b reg=%b required 1/1000", done, sr_q);
        else n_pass++;
        step(); step();
        n_checks++;
        if (busy !== 1'b0 || {s1, s0} !== 2'b00 || sr_q !== 4'b1000)
            $display("FAIL busy_start_noqueue: busy=%b s=%b%b reg=%b required 0/00/1000",
                     busy, s1, s0, sr_q);
        else n_pass++;
    endtask

    initial begin
        start     = 1'b0;
        cmd_dir   = 1'b0;
        cmd_rot   = 1'b0;
        cmd_fill  = 1'b0;
        cmd_count = '0;
        cmd_data  = '0;
        clr       = 1'b0;
        test_reset();
        test_load_only();
        test_right_fill();
        test_right_rotate();
        test_back_to_back();
        test_start_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
